// File: rtl/vend_credit_ctrl_pkg.sv
// Shared types and coin table for the vending credit controller family.
// The coin table is ascending and every entry is a multiple of the smallest
// coin. This guarantees that any credit built from these coins can be paid
// back exactly by the greedy change picker.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam int MAX_COINS = 8;

    localparam int unsigned COIN_VAL [MAX_COINS] = '{1, 5, 10, 25, 50, 100, 200, 500};

    // Returns the value of coin idx; indices past the table read as zero.
    function automatic int unsigned coin_value(input int idx);
        if (idx >= 0 && idx < MAX_COINS) begin
            return COIN_VAL[idx];
        end
        return 0;
    endfunction

    // Checks the first n table entries: strictly ascending, with a non-zero
    // base coin that divides every other coin.
    function automatic bit coin_table_ok(input int n);
        if (n < 1 || n > MAX_COINS || COIN_VAL[0] == 0) begin
            return 1'b0;
        end
        for (int i = 1; i < n; i++) begin
            if (COIN_VAL[i] <= COIN_VAL[i-1]) return 1'b0;
            if ((COIN_VAL[i] % COIN_VAL[0]) != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/vend_credit_ctrl_if.sv
// Handshake bundle between the credit controller and its neighbours: coin
// debouncers, the dispenser and the change hopper.
// The controller uses the master modport because it originates the vend
// and change requests. The environment side uses the slave modport.
interface vend_credit_ctrl_if #(
    parameter int N_COINS  = 4,
    parameter int CREDIT_W = 8
);
    localparam int IDX_W = (N_COINS > 1) ? $clog2(N_COINS) : 1;

    logic [N_COINS-1:0]  coin;
    logic                cancel;
    logic                vend_valid;
    logic                vend_ack;
    logic                chg_valid;
    logic [IDX_W-1:0]    chg_idx;
    logic                chg_ready;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport master (
        input  coin, cancel, vend_ack, chg_ready,
        output vend_valid, chg_valid, chg_idx, coin_reject, credit, busy
    );

    modport slave (
        output coin, cancel, vend_ack, chg_ready,
        input  vend_valid, chg_valid, chg_idx, coin_reject, credit, busy
    );

endinterface

// File: rtl/vend_credit_ctrl_chg_select.sv
// Greedy change picker. For a given credit, it selects the largest coin that
// does not exceed the credit. The picker is purely combinational, so the
// hopper tester can reuse it on its own.
module chg_select
    import vend_pkg::*;
#(
    parameter int N_COINS  = 4,
    parameter int CREDIT_W = 8,
    parameter int IDX_W    = 2
) (
    input  logic [CREDIT_W-1:0] credit_i,
    output logic [IDX_W-1:0]    idx_o,
    output logic [CREDIT_W-1:0] value_o
);

    // The table is ascending, so the last coin that fits is the largest one.
    always_comb begin
        idx_o   = '0;
        value_o = CREDIT_W'(coin_value(0));
        for (int i = 0; i < N_COINS; i++) begin
            if (coin_value(i) <= 32'(credit_i)) begin
                idx_o   = IDX_W'(i);
                value_o = CREDIT_W'(coin_value(i));
            end
        end
    end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending-machine credit controller. It accumulates one-cycle coin pulses up
// to PRICE and handshakes a vend with the dispenser. It then pays back any
// remainder one greedy coin at a time through the change hopper.
// Optional feature: define VEND_REFUND_EN so that cancel in ACCUM refunds
// the whole credit as change. Without the macro, cancel is ignored.
module vend_credit_ctrl
    import vend_pkg::*;
#(
    parameter int N_COINS  = 4,
    parameter int CREDIT_W = 8,
    parameter int PRICE    = 30
) (
    input  logic               clk,
    input  logic               res,
    vend_credit_ctrl_if.master bus
);

    localparam int IDX_W = (N_COINS > 1) ? $clog2(N_COINS) : 1;
    // The coin table tops out below 1024, so 10 spare bits hold any sum.
    localparam int SUM_W = CREDIT_W + 10;
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    if (CREDIT_W < 1 || CREDIT_W > 30) begin : g_bad_width
        $error("vend_credit_ctrl: CREDIT_W must be in 1..30");
    end
    if (PRICE <= 0 || PRICE >= (1 << CREDIT_W)) begin : g_bad_price
        $error("vend_credit_ctrl: PRICE must fit in the credit register");
    end
    if ((PRICE % int'(COIN_VAL[0])) != 0) begin : g_bad_multiple
        $error("vend_credit_ctrl: PRICE must be a multiple of the base coin");
    end
    if (!coin_table_ok(N_COINS)) begin : g_bad_table
        $error("vend_credit_ctrl: coin table must ascend in multiples of the base coin");
    end

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;

    logic [SUM_W-1:0]    coinVal;
    logic [SUM_W-1:0]    sumWide;
    logic                coinAny;
    logic                coinMulti;
    logic                overflow;
    logic                reachPrice;
    logic                cancelHit;
    logic [IDX_W-1:0]    chgIdx;
    logic [CREDIT_W-1:0] chgValue;

    chg_select #(
        .N_COINS  (N_COINS),
        .CREDIT_W (CREDIT_W),
        .IDX_W    (IDX_W)
    ) u_chg_select (
        .credit_i (credit_q),
        .idx_o    (chgIdx),
        .value_o  (chgValue)
    );

`ifdef VEND_REFUND_EN
    assign cancelHit = bus.cancel && (state_q == ACCUM);
`else
    logic unusedCancel;
    assign unusedCancel = bus.cancel;
    assign cancelHit    = 1'b0;
`endif

    // Decode the coin pulse, then choose the next state, credit and reject flag.
    always_comb begin
        coinVal    = '0;
        for (int i = 0; i < N_COINS; i++) begin
            if (bus.coin[i]) coinVal = SUM_W'(coin_value(i));
        end
        coinAny    = |bus.coin;
        coinMulti  = $countones(bus.coin) > 1;
        sumWide    = SUM_W'(credit_q) + coinVal;
        overflow   = |sumWide[SUM_W-1:CREDIT_W];
        reachPrice = sumWide >= SUM_W'(PRICE);

        state_d    = state_q;
        credit_d   = credit_q;
        reject_d   = 1'b0;

        case (state_q)
            IDLE, ACCUM: begin
                if (cancelHit) begin
                    state_d  = CHANGE;
                    reject_d = coinAny;
                end else if (coinMulti) begin
                    reject_d = 1'b1;
                end else if (coinAny) begin
                    if (overflow) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = sumWide[CREDIT_W-1:0];
                        state_d  = reachPrice ? VEND : ACCUM;
                    end
                end
            end
            VEND: begin
                reject_d = coinAny;
                if (bus.vend_ack) begin
                    credit_d = credit_q - PRICE_C;
                    state_d  = (credit_q != PRICE_C) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                reject_d = coinAny;
                if (bus.chg_ready) begin
                    credit_d = credit_q - chgValue;
                    state_d  = (credit_q != chgValue) ? CHANGE : IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    // State, credit and the registered reject pulse; reset drops any pending change.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    assign bus.vend_valid  = (state_q == VEND);
    assign bus.chg_valid   = (state_q == CHANGE);
    assign bus.chg_idx     = chgIdx;
    assign bus.coin_reject = reject_q;
    assign bus.credit      = credit_q;
    assign bus.busy        = (state_q == VEND) || (state_q == CHANGE);

endmodule
